seven_seg_scan_mux: RTL



---
 rtl/seven_seg_pkg.sv | 16 +
 rtl/seven_seg_scan_mux_if.sv | 33 +++
 rtl/seven_seg_refresh_prescaler.sv | 31 +++
 rtl/seven_seg_scan_mux.sv | 129 ++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan multiplexer.
package seven_seg_pkg;

  // Width of one hex digit code handed to the segment decoder.
  localparam int NIBBLE_W = 4;

  // All anodes off (active-low). Wide enough for the largest digit count;
  // users slice the low NUM_DIGITS bits.
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Width of the digit index for a given digit count.
  function automatic int DIGIT_IDX_W(input int num_digits);
    return $clog2(num_digits);
  endfunction

endpackage

// File: rtl/seven_seg_scan_mux_if.sv
// Bus between the value source / display and the scan multiplexer.
//
// Handshake semantics: there is no back-pressure. load is a one-cycle
// strobe sampled on every rising clk edge; digits_in is only meaningful in
// a cycle where load is high. frame_start is a one-cycle output pulse in
// the cycle digit_idx has just wrapped to 0. enable is a level.
interface seven_seg_scan_mux_if
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = DIGIT_IDX_W(NUM_DIGITS);

  logic                           enable;
  logic                           load;
  logic [NIBBLE_W*NUM_DIGITS-1:0] digits_in;
  logic [NIBBLE_W-1:0]            nibble_out;
  logic [NUM_DIGITS-1:0]          anode_n;
  logic [IDX_W-1:0]               digit_idx;
  logic                           frame_start;

  // Value source / display side.
  modport master (
    output enable, load, digits_in,
    input  nibble_out, anode_n, digit_idx, frame_start
  );

  // Scan multiplexer side.
  modport slave (
    input  enable, load, digits_in,
    output nibble_out, anode_n, digit_idx, frame_start
  );
endinterface

// File: rtl/seven_seg_refresh_prescaler.sv
// Divides clk down to one tick per digit slot; counting freezes while
// enable is low so a paused slot resumes with its remaining time.
module seven_seg_refresh_prescaler #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the last count of the slot, then wrap; hold while disabled.
  always_comb begin
    tick  = enable && (cnt_q == CNT_MAX);
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexes a double-buffered multi-digit hex value onto one shared
// nibble bus plus active-low anode selects. New values are committed only
// at frame boundaries so a frame never shows a mix of old and new digits.
// Optional feature macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN (blank leading
// zero digits by keeping their anode high).
module seven_seg_scan_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input logic                clk,
  input logic                rst_n,
  seven_seg_scan_mux_if.slave bus
);
  localparam int IDX_W = DIGIT_IDX_W(NUM_DIGITS);
  localparam int VAL_W = NIBBLE_W * NUM_DIGITS;
  localparam logic [IDX_W-1:0]      IDX_LAST      = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE       = IDX_W'(1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE       = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] ANODE_ALL_OFF = ANODE_OFF[NUM_DIGITS-1:0];

  logic                  tick;
  logic                  idx_wrap;
  logic [NUM_DIGITS-1:0] blank_mask;

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      staging_q, staging_d;
  logic [VAL_W-1:0]      active_q, active_d;
  logic                  pending_q, pending_d;
  logic [NIBBLE_W-1:0]   nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  frame_start_q, frame_start_d;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Bit k set when digit k and every more-significant digit are zero;
  // digit 0 is never blanked.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [VAL_W-1:0] v);
    logic [NUM_DIGITS-1:0] m;
    logic                  all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero && (v[k*NIBBLE_W +: NIBBLE_W] == '0);
      m[k]     = all_zero;
    end
    return m;
  endfunction
`endif

  seven_seg_refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (bus.enable),
    .tick   (tick)
  );

  // Slot advance, staging/commit and the next output image.
  always_comb begin
    idx_wrap = tick && (idx_q == IDX_LAST);
    idx_d    = idx_q;
    if (tick) begin
      idx_d = idx_wrap ? '0 : idx_q + IDX_ONE;
    end

    staging_d = staging_q;
    pending_d = pending_q;
    active_d  = active_q;
    if (bus.load) begin
      staging_d = bus.digits_in;
      pending_d = 1'b1;
    end
    // A load landing on the boundary goes straight to active so the new
    // value shows in the frame that is just starting.
    if (idx_wrap) begin
      if (bus.load) begin
        active_d  = bus.digits_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = staging_q;
        pending_d = 1'b0;
      end
    end

    frame_start_d = idx_wrap;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    blank_mask = lead_zero_mask(active_d);
`else
    blank_mask = '0;
`endif

    // Disabled: anodes off, nibble keeps its last value.
    nibble_d = nibble_q;
    anode_d  = ANODE_ALL_OFF;
    if (bus.enable) begin
      nibble_d = active_d[int'(idx_d)*NIBBLE_W +: NIBBLE_W];
      anode_d  = ~(SEL_ONE << idx_d) | blank_mask;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      staging_q     <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      nibble_q      <= '0;
      anode_q       <= ANODE_ALL_OFF;
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      staging_q     <= staging_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      nibble_q      <= nibble_d;
      anode_q       <= anode_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.nibble_out  = nibble_q;
  assign bus.anode_n     = anode_q;
  assign bus.digit_idx   = idx_q;
  assign bus.frame_start = frame_start_q;
endmodule
